// File: rtl/ss_feeder.sv
// ss_feeder: streams stored W/X matrices to an SS array and captures its result burst
module ss_feeder #(
   parameter int DW = 16,
   parameter int RW = 40,
   parameter int TIMEOUT = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_we,
   input  logic [4:0]    cfg_addr,
   input  logic [DW-1:0] cfg_wdata,
   input  logic          start,
   input  logic          start_size,
   output logic          busy,
   output logic          done,
   output logic          err,
   input  logic [2:0]    res_addr,
   output logic [RW-1:0] res_data,
   output logic          in_valid,
   output logic [DW-1:0] matrix,
   output logic          matrix_size,
   input  logic          out_valid,
   input  logic [RW-1:0] out_value
);
   localparam int CW = ($clog2(TIMEOUT) > 5) ? $clog2(TIMEOUT) : 5;
   typedef enum logic [1:0] {IDLE, SEND, WAIT, RECV} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0] k, k_n;
   logic sz, sz_n, in_valid_n, matrix_size_n, done_n, err_n;
   logic [DW-1:0] matrix_n;
   logic [DW-1:0] mem [32];
   logic [RW-1:0] res [7];
   logic [4:0] nidx, saddr;
   logic last_word, last_res, cap;
   assign nidx = cnt[4:0] + 5'd1;
   assign saddr = sz ? nidx : {nidx[2], 1'b0, nidx[1], 1'b0, nidx[0]};
   assign last_word = cnt == (sz ? CW'(31) : CW'(7));
   assign last_res = k == (sz ? 3'd6 : 3'd2);
   assign cap = out_valid && (state == WAIT || state == RECV);
   assign busy = state != IDLE;
   assign res_data = (res_addr == 3'd7) ? '0 : res[res_addr];
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      k_n = k;
      sz_n = sz;
      in_valid_n = 1'b0;
      matrix_n = '0;
      matrix_size_n = 1'b0;
      done_n = 1'b0;
      err_n = err;
      case (state)
         IDLE: if (start) begin
            state_n = SEND;
            cnt_n = '0;
            k_n = '0;
            sz_n = start_size;
            err_n = 1'b0;
            in_valid_n = 1'b1;
            matrix_n = (cfg_we && cfg_addr == 5'd0) ? cfg_wdata : mem[0];
            matrix_size_n = start_size;
         end
         SEND: if (last_word) begin
            state_n = WAIT;
            cnt_n = CW'(1);
         end else begin
            cnt_n = cnt + CW'(1);
            in_valid_n = 1'b1;
            matrix_n = mem[saddr];
         end
         WAIT: if (out_valid) begin
            state_n = RECV;
            k_n = 3'd1;
         end else if (cnt == CW'(TIMEOUT - 1)) begin
            state_n = IDLE;
            err_n = 1'b1;
            done_n = 1'b1;
         end else
            cnt_n = cnt + CW'(1);
         RECV: if (!out_valid) begin
            state_n = IDLE;
            err_n = 1'b1;
            done_n = 1'b1;
         end else if (last_res) begin
            state_n = IDLE;
            done_n = 1'b1;
         end else
            k_n = k + 3'd1;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         k <= '0;
         sz <= 1'b0;
         in_valid <= 1'b0;
         matrix <= '0;
         matrix_size <= 1'b0;
         done <= 1'b0;
         err <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         k <= k_n;
         sz <= sz_n;
         in_valid <= in_valid_n;
         matrix <= matrix_n;
         matrix_size <= matrix_size_n;
         done <= done_n;
         err <= err_n;
      end
   always_ff @(posedge clk or posedge rst)
      if (rst)
         for (int i = 0; i < 32; i++) mem[i] <= '0;
      else if (state == IDLE && cfg_we)
         mem[cfg_addr] <= cfg_wdata;
   always_ff @(posedge clk or posedge rst)
      if (rst)
         for (int i = 0; i < 7; i++) res[i] <= '0;
      else if (state == IDLE && start)
         for (int i = 0; i < 7; i++) res[i] <= '0;
      else if (cap)
         res[k] <= out_value;
endmodule

// File: tb/tb_ss_feeder.sv
// tb_ss_feeder: directed transactions against a cycle-timeline model of the feeder
module tb_ss_feeder;
   localparam int TO = 64;
   logic clk = 1'b0;
   logic rst, cfg_we, start, start_size, busy, done, err, in_valid, matrix_size, out_valid;
   logic [4:0] cfg_addr;
   logic [15:0] cfg_wdata, matrix;
   logic [2:0] res_addr;
   logic [39:0] res_data, out_value;
   logic e_iv, e_ms, e_busy, e_done, e_err;
   logic [15:0] e_mat;
   logic [15:0] mdl [32];
   logic [15:0] seen [$];
   int total = 0, bad = 0, cyc = 0, last_iv = 0, done_cyc = 0;

   ss_feeder #(.DW(16), .RW(40), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .start(start), .start_size(start_size), .busy(busy), .done(done), .err(err),
      .res_addr(res_addr), .res_data(res_data), .in_valid(in_valid), .matrix(matrix),
      .matrix_size(matrix_size), .out_valid(out_valid), .out_value(out_value)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (in_valid) begin
         seen.push_back(matrix);
         last_iv = cyc;
      end
      if (done) done_cyc = cyc;
      chk("in_valid", 64'(in_valid), 64'(e_iv));
      chk("matrix", 64'(matrix), 64'(e_mat));
      chk("matrix_size", 64'(matrix_size), 64'(e_ms));
      chk("busy", 64'(busy), 64'(e_busy));
      chk("done", 64'(done), 64'(e_done));
      chk("err", 64'(err), 64'(e_err));
   end

   function automatic logic [39:0] rval(input int base, input int j);
      return {8'(j + 1), 32'(base * 16 + j * 7 + 1)};
   endfunction

   function automatic logic [15:0] word(input bit s, input int i);
      if (s) return mdl[i];
      return (i < 4) ? mdl[(i / 2) * 4 + i % 2] : mdl[16 + ((i - 4) / 2) * 4 + (i - 4) % 2];
   endfunction

   task automatic wr(input int a, input logic [15:0] v);
      cfg_we = 1'b1;
      cfg_addr = 5'(a);
      cfg_wdata = v;
      mdl[a] = v;
      @(posedge clk); #1;
      cfg_we = 1'b0;
   endtask

   // d<0: SS never answers; otherwise out_valid starts d cycles after the last word, for b cycles
   task automatic run_txn(input bit s, input int d, input int b, input int base, input bit inj,
                          input int rst_at, input bit w0, input logic [15:0] w0v);
      int n, r, dc;
      bit ee, ov;
      logic [15:0] words [32];
      n = s ? 32 : 8;
      r = s ? 7 : 3;
      if (w0) mdl[0] = w0v;
      for (int i = 0; i < n; i++) words[i] = word(s, i);
      dc = (d < 0) ? n + TO : ((b >= r) ? n + d + r : n + d + b + 1);
      ee = (d < 0) || (b < r);
      seen.delete();
      start = 1'b1;
      start_size = s;
      cfg_we = w0;
      cfg_addr = 5'd0;
      cfg_wdata = w0v;
      @(posedge clk); #1;
      for (int c = 1; c <= dc; c++) begin
         start = 1'b0;
         start_size = 1'b0;
         cfg_we = 1'b0;
         ov = (d >= 0) && (c >= n + d) && (c < n + d + b);
         out_valid = ov || (inj && c == 4);
         out_value = ov ? rval(base, c - n - d) : 40'hDE_AD00_BEEF;
         if (inj && c == 3) begin
            start = 1'b1;
            start_size = 1'b1;
            cfg_we = 1'b1;
            cfg_addr = 5'd1;
            cfg_wdata = 16'hBEEF;
         end
         e_iv = c <= n;
         e_mat = (c <= n) ? words[c - 1] : 16'h0;
         e_ms = (c == 1) ? s : 1'b0;
         e_busy = c < dc;
         e_done = c == dc;
         e_err = (c == dc) ? ee : 1'b0;
         if (c == rst_at) begin
            #2 rst = 1'b1;
            {e_iv, e_mat, e_ms, e_busy, e_done, e_err} = '0;
            for (int i = 0; i < 32; i++) mdl[i] = '0;
            #1;
            chk("rst_in_valid", 64'(in_valid), 64'd0);
            chk("rst_matrix", 64'(matrix), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            out_valid = 1'b0;
            cfg_we = 1'b0;
            start = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0;
            return;
         end
         if (c == dc)
            for (int i = 0; i < 8; i++) begin
               res_addr = 3'(i);
               #1 chk("res", 64'(res_data), 64'((d >= 0 && i < b && i < r) ? rval(base, i) : 40'h0));
            end
         @(posedge clk); #1;
      end
      out_valid = 1'b0;
      {e_iv, e_mat, e_ms, e_busy, e_done} = '0;
      e_err = ee;
   endtask

   initial begin
      rst = 1'b1;
      {cfg_we, start, start_size, out_valid} = '0;
      cfg_addr = '0;
      cfg_wdata = '0;
      res_addr = '0;
      out_value = '0;
      {e_iv, e_mat, e_ms, e_busy, e_done, e_err} = '0;
      for (int i = 0; i < 32; i++) mdl[i] = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_err", 64'(err), 64'd0);
      chk("reset_res0", 64'(res_data), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      // 2x2: W=[1,2;3,4], X=[5,6;7,8]
      wr(0, 1); wr(1, 2); wr(4, 3); wr(5, 4);
      wr(16, 5); wr(17, 6); wr(20, 7); wr(21, 8);
      run_txn(0, 3, 3, 1, 0, 0, 0, 0);
      chk("t1_len", 64'(seen.size()), 64'd8);
      for (int i = 0; i < 8; i++) chk("t1_word", 64'(seen[i]), 64'(i + 1));
      res_addr = 3'd0;
      #1 chk("t1_res0", 64'(res_data), 64'h01_0000_0011);
      // 4x4: W=I, X=1..16
      for (int i = 0; i < 16; i++) wr(i, (i / 4 == i % 4) ? 16'd1 : 16'd0);
      for (int i = 0; i < 16; i++) wr(16 + i, 16'(i + 1));
      run_txn(1, 5, 7, 2, 0, 0, 0, 0);
      chk("t2_len", 64'(seen.size()), 64'd32);
      chk("t2_w00", 64'(seen[0]), 64'd1);
      chk("t2_w01", 64'(seen[1]), 64'd0);
      chk("t2_w11", 64'(seen[5]), 64'd1);
      chk("t2_x00", 64'(seen[16]), 64'd1);
      chk("t2_x33", 64'(seen[31]), 64'd16);
      // timeout
      run_txn(0, -1, 0, 3, 0, 0, 0, 0);
      chk("t3_latency", 64'(done_cyc - last_iv), 64'd64);
      chk("t3_err", 64'(err), 64'd1);
      // broken burst, 4x4
      run_txn(1, 1, 2, 4, 0, 0, 0, 0);
      res_addr = 3'd2;
      #1 chk("t4_res2", 64'(res_data), 64'd0);
      // ignored start/cfg/out_valid during SEND, then back-to-back start with same-cycle write
      run_txn(0, 2, 4, 5, 1, 0, 0, 0);
      run_txn(0, 1, 3, 6, 0, 0, 1, 16'h00AA);
      chk("t5_w0_new", 64'(seen[0]), 64'h00AA);
      chk("t5_w1_kept", 64'(seen[1]), 64'd0);
      // reset mid-SEND, then storage streams as zeros
      run_txn(1, 5, 7, 7, 0, 11, 0, 0);
      @(posedge clk); #1;
      run_txn(1, 3, 7, 8, 0, 0, 0, 0);
      chk("t6_len", 64'(seen.size()), 64'd32);
      for (int i = 0; i < 32; i++) chk("t6_zero", 64'(seen[i]), 64'd0);
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
